// File: rtl/MemoryBus.sv
// MemoryBus: command/result structs shared by all memory-bus slaves
package MemoryBus;
  typedef struct packed {
    logic        start;
    logic        mem_read;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;
  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } Result;
endpackage

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and serialiser states for uart_tx_slave
package uart_pkg;
  localparam int BAUD_W = 16;
  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_BAUD = 2'd2;
  localparam logic [1:0] UART_REG_RSVD = 2'd3;
  localparam int STATUS_FULL = 0;
  localparam int STATUS_EMPTY = 1;
  localparam int STATUS_BUSY = 2;
  localparam int STATUS_COUNT_LSB = 8;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO; push while full is accepted only alongside a pop
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // storage array, written on every accepted push
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter with TX FIFO; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_slave import uart_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV_RESET = 433
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       bus_address,
  input  logic             write_enable,
  input  MemoryBus::Cmd    cmd,
  output MemoryBus::Result result,
  output logic             tx_o,
  output logic [7:0]       tx_byte_o,
  output logic             tx_byte_valid_o,
  output logic             irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic full, empty, push, pop, wr, rd, tx_wr, stall, bit_end, busy, done_d, done_q, pend_q;
  logic [CW-1:0] count;
  logic [7:0] rdata, push_data, pend_data_q, sh_q, txb_q;
  logic [31:0] status, data_d, data_q;
  logic [BAUD_W-1:0] baud_div_d, baud_div_q, baud_q, cnt_q;
  logic [2:0] bit_q;
  logic tx_q, vld_q, irq_q;
  tx_state_t state_q;
  logic unused_bits;
  assign unused_bits = ^{cmd.mem_read, cmd.mask_byte[3:2], cmd.write_data[31:16]};
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .wdata_i(push_data), .pop_i(pop),
    .rdata_o(rdata), .full_o(full), .empty_o(empty), .count_o(count)
  );
  // bus decode: a TXDATA write into a full FIFO parks in the pending slot until the serialiser pops
  always_comb begin
    wr = cmd.start && write_enable && !pend_q;
    rd = cmd.start && !write_enable && !pend_q;
    tx_wr = wr && bus_address == UART_REG_TXDATA && cmd.mask_byte[0];
    bit_end = cnt_q == baud_q;
    busy = state_q != TX_IDLE;
    pop = !empty && (state_q == TX_IDLE || (state_q == TX_STOP && bit_end));
    stall = tx_wr && full && !pop;
    push = (tx_wr && !stall) || (pend_q && pop);
    push_data = pend_q ? pend_data_q : cmd.write_data[7:0];
    done_d = (cmd.start && !pend_q && !stall) || (pend_q && pop);
    status = (32'(count) << STATUS_COUNT_LSB) | (32'(busy) << STATUS_BUSY) |
             (32'(empty) << STATUS_EMPTY) | (32'(full) << STATUS_FULL);
    data_d = (!rd || bus_address == UART_REG_RSVD) ? '0 :
             bus_address == UART_REG_STATUS ? status :
             bus_address == UART_REG_BAUD ? 32'(baud_div_q) : '0;
    baud_div_d = (wr && bus_address == UART_REG_BAUD) ?
                 {cmd.mask_byte[1] ? cmd.write_data[15:8] : baud_div_q[15:8],
                  cmd.mask_byte[0] ? cmd.write_data[7:0] : baud_div_q[7:0]} : baud_div_q;
  end
  // bus-side registers: response, pending write and divisor
  always_ff @(posedge clk)
    if (rst) begin
      done_q <= 1'b0;
      data_q <= '0;
      pend_q <= 1'b0;
      pend_data_q <= '0;
      baud_div_q <= BAUD_W'(BAUD_DIV_RESET);
    end else begin
      done_q <= done_d;
      data_q <= data_d;
      pend_q <= pend_q ? !pop : stall;
      if (stall) pend_data_q <= cmd.write_data[7:0];
      baud_div_q <= baud_div_d;
    end
  // serialiser: every state holds for baud_q+1 cycles; a pop from STOP restarts without an idle gap
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= TX_IDLE;
      tx_q <= 1'b1;
      vld_q <= 1'b0;
      txb_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      baud_q <= '0;
      irq_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
      irq_q <= empty && !busy;
      cnt_q <= (bit_end || !busy) ? '0 : cnt_q + 1'b1;
      if (pop) begin
        state_q <= TX_START;
        tx_q <= 1'b0;
        vld_q <= 1'b1;
        txb_q <= rdata;
        sh_q <= rdata;
        baud_q <= baud_div_q;
        cnt_q <= '0;
      end else
        case (state_q)
          TX_START: if (bit_end) begin
            state_q <= TX_DATA;
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
            bit_q <= '0;
          end
          TX_DATA: if (bit_end) begin
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= TX_PARITY;
              tx_q <= ^txb_q;
`else
              state_q <= TX_STOP;
              tx_q <= 1'b1;
`endif
            end
          end
          TX_PARITY: if (bit_end) begin
            state_q <= TX_STOP;
            tx_q <= 1'b1;
          end
          TX_STOP: if (bit_end) state_q <= TX_IDLE;
          default: state_q <= TX_IDLE;
        endcase
    end
  assign result.done = done_q;
  assign result.data = data_q;
  assign tx_o = tx_q;
  assign tx_byte_o = txb_q;
  assign tx_byte_valid_o = vld_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: scoreboard bench for uart_tx_slave (bus responses, byte strobes, serial frames)
module tb_uart_tx_slave;
  typedef struct {
    logic [7:0] b;
    int per;
    bit b2b;
  } fr_t;
  logic clk = 0, rst = 1, write_enable = 0;
  logic [1:0] bus_address = 0;
  MemoryBus::Cmd cmd = '0;
  MemoryBus::Result result;
  logic tx_o, tx_byte_valid_o, irq_o;
  logic [7:0] tx_byte_o;
  int tests = 0, fails = 0;
  bit fmon_en = 1;
  logic [31:0] rq[$];
  logic [7:0] bq[$];
  fr_t fq[$];

  uart_tx_slave dut (
    .clk(clk), .rst(rst), .bus_address(bus_address), .write_enable(write_enable), .cmd(cmd),
    .result(result), .tx_o(tx_o), .tx_byte_o(tx_byte_o), .tx_byte_valid_o(tx_byte_valid_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", n, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] a, input logic [3:0] m, input logic [31:0] wd,
                     input logic [31:0] exp, output int lat);
    rq.push_back(we ? 32'd0 : exp);
    write_enable = we;
    bus_address = a;
    cmd.start = 1;
    cmd.mem_read = !we;
    cmd.mask_byte = m;
    cmd.write_data = wd;
    @(negedge clk);
    cmd.start = 0;
    lat = 1;
    while (result.done !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (result.done !== 1'b1) chk("bus_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b, input int per, input bit b2b, output int lat);
    bq.push_back(b);
    fq.push_back('{b: b, per: per, b2b: b2b});
    bus(1, 0, 4'b0001, {24'h0, b}, 0, lat);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((fq.size() != 0 || bq.size() != 0 || rq.size() != 0 || irq_o !== 1'b1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < 5000, 1);
  endtask

  // bus response monitor
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (result.done === 1'b1) begin
      if (rq.size() == 0) chk("bus_unexpected_done", 1, 0);
      else begin
        e = rq.pop_front();
        chk("bus_data", result.data, e);
      end
    end
  end

  // byte strobe monitor
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (tx_byte_valid_o === 1'b1) begin
      if (bq.size() == 0) chk("byte_unexpected", 1, 0);
      else begin
        e = bq.pop_front();
        chk("tx_byte", tx_byte_o, e);
      end
    end
  end

  // serial line monitor: checks every cycle of every bit and the gap before back-to-back frames
  initial begin
    int gap = 0, nb, k;
    fr_t e;
    logic [10:0] bits;
    bit ok;
    forever begin
      @(negedge clk);
      if (fmon_en && !rst && tx_o === 1'b0) begin
        if (fq.size() == 0) begin
          chk("frame_unexpected", 1, 0);
          k = 0;
          while (tx_o === 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
          end
        end else begin
          e = fq.pop_front();
`ifdef UART_TX_PARITY_EN
          bits = {1'b1, ^e.b, e.b, 1'b0};
          nb = 11;
`else
          bits = {2'b01, e.b, 1'b0};
          nb = 10;
`endif
          ok = 1;
          for (int b = 0; b < nb; b++)
            for (int c = 0; c < e.per; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (tx_o !== bits[b]) ok = 0;
            end
          chk($sformatf("frame_%02h_bits", e.b), {31'd0, ok}, 1);
          if (e.b2b) chk($sformatf("frame_%02h_gap", e.b), gap, 0);
        end
        gap = 0;
      end else gap++;
    end
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, result.done}, 0);
    chk("rst_data", result.data, 0);
    chk("rst_tx", {31'd0, tx_o}, 1);
    chk("rst_valid", {31'd0, tx_byte_valid_o}, 0);
    chk("rst_irq", {31'd0, irq_o}, 1);
    rst = 0;
    @(negedge clk);
    bus(0, 1, 4'h0, 0, 32'h2, lat);
    chk("status_lat", lat, 1);
    bus(0, 2, 4'h0, 0, 32'd433, lat);
    bus(0, 3, 4'h0, 0, 0, lat);
    bus(0, 0, 4'h0, 0, 0, lat);
    bus(1, 2, 4'b0011, 32'h3, 0, lat);
    send(8'h55, 4, 0, lat);
    chk("txdata_lat", lat, 1);
    @(negedge clk);
    chk("irq_busy", {31'd0, irq_o}, 0);
    bus(0, 1, 4'h0, 0, 32'h6, lat);
    wait_idle();
    bus(0, 1, 4'h0, 0, 32'h2, lat);
    bus(1, 0, 4'b0000, 32'hAA, 0, lat);
    chk("masked_lat", lat, 1);
    bus(1, 1, 4'hF, 32'hFFFF, 0, lat);
    bus(1, 3, 4'hF, 32'hFFFF, 0, lat);
    bus(0, 1, 4'h0, 0, 32'h2, lat);
    bus(0, 3, 4'h0, 0, 0, lat);
    bus(1, 2, 4'b0010, 32'h0500, 0, lat);
    bus(0, 2, 4'h0, 0, 32'h0503, lat);
    bus(1, 2, 4'b0011, 32'h3, 0, lat);
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i), 4, i != 0, lat);
    bus(0, 1, 4'h0, 0, 32'h1005, lat);
    send(8'h21, 4, 1, lat);
    chk("stall_lat", lat, 24);
    bus(0, 1, 4'h0, 0, 32'h1005, lat);
    wait_idle();
    send(8'h3C, 4, 0, lat);
    repeat (10) @(negedge clk);
    bus(1, 2, 4'b0011, 32'h2, 0, lat);
    send(8'hC3, 3, 1, lat);
    bus(0, 2, 4'h0, 0, 32'h2, lat);
    wait_idle();
    send(8'h07, 3, 0, lat);
    send(8'h03, 3, 1, lat);
    wait_idle();
    fmon_en = 0;
    bq.push_back(8'hF0);
    bus(1, 0, 4'b0001, 32'hF0, 0, lat);
    repeat (13) @(negedge clk);
    chk("pre_rst_busy", {31'd0, irq_o}, 0);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx_o}, 1);
    chk("mid_rst_irq", {31'd0, irq_o}, 1);
    chk("mid_rst_done", {31'd0, result.done}, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_tx", {31'd0, tx_o}, 1);
    fmon_en = 1;
    bus(0, 1, 4'h0, 0, 32'h2, lat);
    bus(0, 2, 4'h0, 0, 32'd433, lat);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
